sprite_line_loader: RTL and testbench

Sits directly downstream of the OAM scanner in the sprite engine. Starts on the per-line `clear` pulse and requests sprite configs from the scanner continuously. Each config the scanner acknowledges as in range for the row is written, in OAM order, into the next free slot of the per-line sprite slot buffer. After the OAM scan completes it invalidates the unused slots, reports count and overflow, and pulses line_done to the line renderer.

---
 rtl/sprite_line_loader_pkg.sv | 15 +
 rtl/sprite_line_loader_counter.sv | 25 ++
 rtl/sprite_line_loader.sv | 156 +++++++++++++++
 tb/tb_sprite_line_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_loader_pkg.sv
// Shared sprite engine definitions: OAM entry layout and engine-wide sizes.
// Also used by the OAM scanner, so changes here affect both blocks.
package sprite_line_loader_pkg;

    localparam int MAX_SPRITES  = 64;
    localparam int SPRITE_SLOTS = 32;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] tile;
        logic [7:0] attr;
    } sprite_conf_t;

endpackage

// File: rtl/sprite_line_loader_counter.sv
// Generic up-counter with synchronous clear; the loader uses it as the
// FLUSH offset from the first unused slot.
module sprite_line_loader_counter #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            value_reg <= '0;
        end else if (inc) begin
            value_reg <= value_reg + W'(1);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/sprite_line_loader.sv
// Per-line sprite loader: copies in-range OAM configs into the slot buffer
// in OAM order, then invalidates the unused slots and signals line_done.
module sprite_line_loader
    import sprite_line_loader_pkg::*;
#(
    parameter  int SLOTS  = SPRITE_SLOTS,
    localparam int SLOT_W = $clog2(SLOTS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              conf_req,
    input  logic              conf_ack,
    input  logic              conf_exists,
    input  logic              oam_read,
    input  logic              oam_avail,
    input  sprite_conf_t      oam_data,
    output logic              slot_we,
    output logic [SLOT_W-1:0] slot_addr,
    output logic              slot_valid,
    output sprite_conf_t      slot_conf,
    output logic [SLOT_W:0]   sprite_count,
    output logic              overflow,
    output logic              busy,
    output logic              line_done
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W+1)'(SLOTS);
    localparam logic [SLOT_W:0] LAST_SLOT  = (SLOT_W+1)'(SLOTS - 1);

    state_t          state_reg, state_next;
    logic            pending_reg, pending_next;
    logic            cap_valid_reg, cap_valid_next;
    sprite_conf_t    cap_conf_reg, cap_conf_next;
    logic [SLOT_W:0] count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            line_done_reg, line_done_next;

    logic [SLOT_W:0] flush_offset;
    logic [SLOT_W:0] flush_addr;
    logic [SLOT_W:0] eff_count;
    logic            flush_inc;

    assign flush_inc = (state_reg == FLUSH);

    sprite_line_loader_counter #(.W(SLOT_W + 1)) u_flush_ctr (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (flush_inc),
        .value (flush_offset)
    );

    assign flush_addr = count_reg + flush_offset;
    // A capture from last cycle is being written now but not yet counted.
    assign eff_count  = count_reg + (SLOT_W+1)'(cap_valid_reg);

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        cap_valid_next = 1'b0;
        cap_conf_next  = cap_conf_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        line_done_next = 1'b0;
        conf_req       = 1'b0;
        slot_we        = 1'b0;
        slot_addr      = '0;
        slot_valid     = 1'b0;
        slot_conf      = '0;

        if (oam_read) begin
            pending_next = 1'b1;
        end else if (oam_avail) begin
            pending_next = 1'b0;
        end

        case (state_reg)
            SCAN: begin
                conf_req = 1'b1;
                if (cap_valid_reg) begin
                    slot_we    = 1'b1;
                    slot_addr  = count_reg[SLOT_W-1:0];
                    slot_valid = 1'b1;
                    slot_conf  = cap_conf_reg;
                    count_next = count_reg + (SLOT_W+1)'(1);
                end
                if (oam_avail && conf_ack) begin
                    if (eff_count < SLOT_LIMIT) begin
                        cap_valid_next = 1'b1;
                        cap_conf_next  = oam_data;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
                if (!conf_exists && !pending_reg && !oam_read && !cap_valid_reg) begin
                    if (count_reg < SLOT_LIMIT) begin
                        state_next = FLUSH;
                    end else begin
                        state_next     = IDLE;
                        line_done_next = 1'b1;
                    end
                end
            end
            FLUSH: begin
                slot_we   = 1'b1;
                slot_addr = flush_addr[SLOT_W-1:0];
                if (flush_addr == LAST_SLOT) begin
                    state_next     = IDLE;
                    line_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // clear starts a fresh line from any state, discarding partial work.
        if (clear) begin
            state_next     = SCAN;
            pending_next   = 1'b0;
            cap_valid_next = 1'b0;
            count_next     = '0;
            overflow_next  = 1'b0;
            line_done_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            cap_valid_reg <= 1'b0;
            cap_conf_reg  <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            line_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            cap_valid_reg <= cap_valid_next;
            cap_conf_reg  <= cap_conf_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            line_done_reg <= line_done_next;
        end
    end

    assign sprite_count = count_reg;
    assign overflow     = overflow_reg;
    assign busy         = (state_reg != IDLE);
    assign line_done    = line_done_reg;

endmodule

// File: tb/tb_sprite_line_loader.sv
// Scoreboard bench for sprite_line_loader: a behavioural OAM scanner drives
// the loader; expected slot writes and line_done results are queued and
// checked by an independent monitor.
module tb_sprite_line_loader;
    import sprite_line_loader_pkg::*;

    logic         clock = 1'b0;
    logic         reset, clear, conf_ack, conf_exists, oam_read, oam_avail;
    sprite_conf_t oam_data;
    logic         conf_req, slot_we, slot_valid, overflow, busy, line_done;
    logic [4:0]   slot_addr;
    sprite_conf_t slot_conf;
    logic [5:0]   sprite_count;

    typedef struct packed {
        logic [4:0]   addr;
        logic         valid;
        sprite_conf_t conf;
    } wr_t;

    typedef struct packed {
        logic [5:0] count;
        logic       ovf;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    sprite_line_loader dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .conf_req     (conf_req),
        .conf_ack     (conf_ack),
        .conf_exists  (conf_exists),
        .oam_read     (oam_read),
        .oam_avail    (oam_avail),
        .oam_data     (oam_data),
        .slot_we      (slot_we),
        .slot_addr    (slot_addr),
        .slot_valid   (slot_valid),
        .slot_conf    (slot_conf),
        .sprite_count (sprite_count),
        .overflow     (overflow),
        .busy         (busy),
        .line_done    (line_done)
    );

    always #5 clock = ~clock;

    // OAM entry i holds y=i, x=3i, tile=i+16, attr=i^0x40 (entry 5 -> 05_0f_15_45).
    function automatic sprite_conf_t conf_of(input int i);
        sprite_conf_t c;
        c.y    = 8'(i);
        c.x    = 8'(i * 3);
        c.tile = 8'(i + 16);
        c.attr = 8'(i) ^ 8'h40;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write / line_done is matched against the queues.
    always @(negedge clock) begin
        if (slot_we) begin
            $display("write slot=%0d valid=%0d conf=%08h", slot_addr, slot_valid, slot_conf);
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got slot %0d, expected no write", slot_addr);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("slot_addr", 64'(slot_addr), 64'(e.addr));
                check("slot_valid", 64'(slot_valid), 64'(e.valid));
                check("slot_conf", 64'(slot_conf), 64'(e.conf));
            end
        end
        if (line_done) begin
            $display("line_done count=%0d overflow=%0d", sprite_count, overflow);
            if (exp_done.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_line_done: got pulse, expected none");
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("sprite_count", 64'(sprite_count), 64'(d.count));
                check("overflow", 64'(overflow), 64'(d.ovf));
                check("writes_left_at_done", 64'(exp_wr.size()), 64'd0);
            end
        end
    end

    task automatic push_wr(input int addr, input logic valid, input sprite_conf_t c);
        wr_t e;
        e.addr  = 5'(addr);
        e.valid = valid;
        e.conf  = c;
        exp_wr.push_back(e);
    endtask

    // Queue the expected slot image for a line given the in-range entry mask.
    task automatic expect_line(input logic [63:0] mask, input bit finish);
        int   k = 0;
        logic ovf = 1'b0;
        done_t d;
        for (int i = 0; i < 64; i++) begin
            if (mask[i]) begin
                if (k < 32) begin
                    push_wr(k, 1'b1, conf_of(i));
                    k++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        if (finish) begin
            for (int s = k; s < 32; s++) push_wr(s, 1'b0, '0);
            d.count = 6'(k);
            d.ovf   = ovf;
            exp_done.push_back(d);
        end
    endtask

    task automatic start_line();
        @(posedge clock); #1;
        clear       = 1'b1;
        conf_exists = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    // Behavioural scanner: one outstanding read, avail 'lat' cycles after read;
    // with lat=1 the next read overlaps the previous avail.
    task automatic scan_line(input int lat, input logic [63:0] mask, input int n_entries);
        int  next_rd  = 0;
        int  idx      = 0;
        int  timer    = 0;
        bit  inflight = 0;
        bit  exists_now;
        do begin
            @(posedge clock); #1;
            oam_read  = 1'b0;
            oam_avail = 1'b0;
            conf_ack  = 1'b0;
            oam_data  = '0;
            if (inflight) begin
                timer--;
                if (timer == 0) begin
                    oam_avail = 1'b1;
                    oam_data  = conf_of(idx);
                    conf_ack  = mask[idx];
                    inflight  = 0;
                end
            end
            exists_now = (next_rd < 64);
            if (!inflight && next_rd < n_entries && conf_req) begin
                oam_read = 1'b1;
                idx      = next_rd;
                next_rd++;
                timer    = lat;
                inflight = 1;
            end
            conf_exists = exists_now;
        end while (next_rd < n_entries || inflight);
        @(posedge clock); #1;
        oam_read  = 1'b0;
        oam_avail = 1'b0;
        conf_ack  = 1'b0;
        oam_data  = '0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && (exp_wr.size() != 0 || exp_done.size() != 0); i++)
            @(posedge clock);
        @(negedge clock);
        if (exp_wr.size() != 0 || exp_done.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d writes / %0d done pending, expected 0",
                     name, exp_wr.size(), exp_done.size());
            exp_wr.delete();
            exp_done.delete();
        end
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        conf_ack    = 1'b0;
        conf_exists = 1'b0;
        oam_read    = 1'b0;
        oam_avail   = 1'b0;
        oam_data    = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_conf_req", 64'(conf_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(sprite_count), 64'd0);

        // Test 1: reset in SCAN after two writes.
        start_line();
        expect_line(64'h3, 1'b0);
        scan_line(1, 64'h3, 3);
        repeat (3) @(posedge clock);
        check("t1_count_before_reset", 64'(sprite_count), 64'd2);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("t1_outputs_zero",
              64'({conf_req, slot_we, slot_addr, slot_valid, slot_conf,
                   sprite_count, overflow, busy, line_done}), 64'd0);
        repeat (3) begin
            @(negedge clock);
            check("t1_conf_req_idle", 64'(conf_req), 64'd0);
        end
        check("t1_writes_drained", 64'(exp_wr.size()), 64'd0);

        // Test 2: entries 5, 10, 63 in range.
        start_line();
        expect_line((64'd1 << 5) | (64'd1 << 10) | (64'd1 << 63), 1'b1);
        scan_line(1, (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 63), 64);
        wait_done("t2");

        // Test 3: 33 entries in range -> overflow, no flush.
        start_line();
        expect_line(64'h1_FFFF_FFFF, 1'b1);
        scan_line(1, 64'h1_FFFF_FFFF, 64);
        wait_done("t3");
        check("t3_count_held", 64'(sprite_count), 64'd32);
        check("t3_overflow_held", 64'(overflow), 64'd1);

        // Test 4: only entry 63, read latency 4.
        start_line();
        expect_line(64'd1 << 63, 1'b1);
        scan_line(4, 64'd1 << 63, 64);
        wait_done("t4");

        // Test 5: abort after two writes, then a fresh line with 7 and 9.
        start_line();
        expect_line(64'h6, 1'b0);
        scan_line(1, 64'h6, 4);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("t5_count_before_abort", 64'(sprite_count), 64'd2);
        start_line();
        @(negedge clock);
        check("t5_count_after_abort", 64'(sprite_count), 64'd0);
        check("t5_busy_after_abort", 64'(busy), 64'd1);
        expect_line((64'd1 << 7) | (64'd1 << 9), 1'b1);
        scan_line(1, (64'd1 << 7) | (64'd1 << 9), 64);
        wait_done("t5");

        // Test 6: nothing in range.
        start_line();
        expect_line(64'd0, 1'b1);
        scan_line(2, 64'd0, 64);
        wait_done("t6");

        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
